modport_bridge: RTL and testbench
=================================

Name: modport_bridge

Overview:
- AHB-Lite slave to APB master bridge.
- Converts each valid AHB transfer into one two-phase APB transfer (SETUP, then ENABLE) to one of four APB slaves.
- Decodes the slave from the AHB address and stalls the AHB master with hreadyout during APB phases.
- Sits between the system AHB bus and the peripheral APB segment.

Parameters:
- BASE_ADDR, 32'h8000_0000, start of the APB window.
- REGION_BITS, 26, log2 of each slave's region size (64 MB); four contiguous regions follow BASE_ADDR.

Ports:
- clk  input  1  bridge clock (AHB and APB share it).
- hresetn  input  1  asynchronous active-low reset.
- htrans  input  2  AHB transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- hwrite  input  1  1 = write, 0 = read.
- hreadyin  input  1  bus ready from the AHB interconnect.
- hsize  input  3  transfer size; accepted, ignored (all transfers 32-bit).
- haddr  input  32  AHB address.
- hwdata  input  32  AHB write data, valid in the data phase.
- hburst  input  3  burst type; accepted, ignored (each beat is an independent APB transfer).
- hreadyout  output  1  bridge ready to the AHB master.
- hresp  output  2  response; 2'b00 OKAY.
- hrdata  output  32  read data to the AHB master.
- pwrite  output  1  APB direction.
- pselx  output  4  one-hot APB slave select.
- penable  output  1  APB enable phase.
- paddr  output  32  APB address.
- pwdata  output  32  APB write data.
- prdata  input  32  APB read data.

Behaviour:
- valid = hreadyin & htrans[1] & (haddr within BASE_ADDR .. BASE_ADDR + 4*2^REGION_BITS - 1).
- Slave index = haddr[REGION_BITS+1:REGION_BITS] relative to BASE_ADDR:
  - 0x8000_0000-0x83FF_FFFF -> pselx 0001
  - 0x8400_0000 -> 0010
  - 0x8800_0000 -> 0100
  - 0x8C00_0000-0x8FFF_FFFF -> 1000
- When valid is sampled in an accepting state, haddr and hwrite are registered (addr_r, write_r) and the slave index is decoded from addr_r.
- FSM states: IDLE, READ, RENABLE, WWAIT, WRITE, WENABLE.
- Accepting states are IDLE, RENABLE and WENABLE. From these:
  - valid & !hwrite -> READ
  - valid & hwrite -> WWAIT
  - otherwise -> IDLE
- Fixed transitions: READ -> RENABLE; WWAIT -> WRITE (hwdata captured into pwdata); WRITE -> WENABLE.
- Outputs are registered, updated on the clock edge entering each state:
  - IDLE: pselx=0, penable=0, hreadyout=1.
  - READ: pselx=decode, paddr=addr_r, pwrite=0, penable=0, hreadyout=0.
  - RENABLE: pselx held, penable=1, hreadyout=1.
  - WWAIT: pselx=0, penable=0, hreadyout=0.
  - WRITE: pselx=decode, paddr=addr_r, pwrite=1, pwdata=captured, penable=0, hreadyout=0.
  - WENABLE: penable=1, hreadyout=1.
- hrdata = prdata combinationally. It is valid to the master in RENABLE, where hreadyout=1 completes the AHB data phase.
- Latency per transfer:
  - read: 2 data-phase cycles;
  - write: 3 data-phase cycles (WWAIT, WRITE, WENABLE).
- Back-to-back transfers are accepted in the ENABLE states with no IDLE bubble.
- hresp is always 2'b00.
- Invalid address, htrans IDLE/BUSY, or hreadyin=0: transfer ignored; no APB activity; hreadyout stays 1.
- Reset (asynchronous, any state, including mid-transfer): state IDLE; pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0, hreadyout=1, hresp=0. An in-flight APB transfer is abandoned.
- pselx is one-hot or zero in all states; penable is never 1 without a nonzero pselx.

Optional Feature:
- Macro: BRIDGE_ERROR_RESP_EN.
- Defined: a transfer with htrans NONSEQ/SEQ, hreadyin=1 and an address outside the window enters ERR1 then ERR2, with no APB activity:
  - ERR1: hresp=01, hreadyout=0.
  - ERR2: hresp=01, hreadyout=1; then behaves as an accepting state.
- Undefined: such transfers are silently ignored with an OKAY response, as described under Behaviour.

Test Plan:
- Reset: hresetn=0 mid-write (in WRITE state) -> next cycle pselx=0, penable=0, hreadyout=1, hresp=00; no APB enable phase occurs.
- Single write: haddr=0x8000_0010, hwrite=1, htrans=2, then hwdata=0xDEAD_BEEF -> WRITE: pselx=0001, paddr=0x8000_0010, pwrite=1, pwdata=0xDEAD_BEEF, penable=0; next cycle penable=1, hreadyout=1.
- Single read: haddr=0x8800_0004, prdata=0x1234_5678 -> pselx=0100, pwrite=0, penable 0 then 1; hrdata=0x1234_5678 with hreadyout=1 in RENABLE.
- Back-to-back: read 0x8400_0000, then read 0x8C00_0000 presented during RENABLE -> second SETUP follows immediately with pselx=1000; no IDLE cycle.
- Ignored transfers: htrans=1 (BUSY) at 0x8000_0000, or htrans=2 at 0x9000_0000 -> pselx stays 0, hreadyout=1, hresp=00 (with BRIDGE_ERROR_RESP_EN the second gives hresp=01 for 2 cycles, hreadyout 0 then 1).
- hreadyin=0 with htrans=2 at 0x8000_0000 -> no transfer started; then hreadyin=1 -> transfer starts the next cycle.

Source files
------------

// File: rtl/modport_bridge.sv
// rtl/modport_bridge.sv - AHB-Lite slave to four-slave APB master bridge.
// Optional error response for out-of-window transfers: define BRIDGE_ERROR_RESP_EN.
module modport_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          REGION_BITS = 26
) (
  input  logic        clk,
  input  logic        hresetn,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [2:0]  hburst,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic        pwrite,
  output logic [3:0]  pselx,
  output logic        penable,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata
);

  typedef enum logic [2:0] {
    IDLE, READ, RENABLE, WWAIT, WRITE, WENABLE, ERR1, ERR2
  } state_t;

  state_t      state;
  logic [31:0] addr_r;
  logic        write_r;
  logic [31:0] haddr_off;
  logic [31:0] addr_r_off;
  logic        in_window;
  logic        valid;
  logic        accepting;
  logic        unused;

  // Offsets below BASE_ADDR wrap to large values, so one upper-bit test covers both window edges.
  assign haddr_off  = haddr - BASE_ADDR;
  assign addr_r_off = addr_r - BASE_ADDR;
  assign in_window  = (haddr_off[31:REGION_BITS+2] == '0);
  assign valid      = hreadyin & htrans[1] & in_window;
  assign accepting  = (state == IDLE) || (state == RENABLE) || (state == WENABLE) || (state == ERR2);
  assign hrdata     = prdata;
  assign unused     = ^{hsize, hburst, haddr_off, addr_r_off};

  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= IDLE;
      addr_r    <= '0;
      write_r   <= 1'b0;
      pselx     <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      hreadyout <= 1'b1;
      hresp     <= 2'b00;
    end else if (accepting) begin
      penable <= 1'b0;
      hresp   <= 2'b00;
      if (valid) begin
        addr_r    <= haddr;
        write_r   <= hwrite;
        hreadyout <= 1'b0;
        if (!hwrite) begin
          // Reads go straight to SETUP; the decode uses haddr as it is being latched into addr_r.
          state  <= READ;
          pselx  <= 4'b0001 << haddr_off[REGION_BITS+1:REGION_BITS];
          paddr  <= haddr;
          pwrite <= 1'b0;
        end else begin
          state <= WWAIT;
          pselx <= '0;
        end
`ifdef BRIDGE_ERROR_RESP_EN
      end else if (hreadyin && htrans[1]) begin
        state     <= ERR1;
        pselx     <= '0;
        hreadyout <= 1'b0;
        hresp     <= 2'b01;
`endif
      end else begin
        state     <= IDLE;
        pselx     <= '0;
        hreadyout <= 1'b1;
      end
    end else begin
      case (state)
        READ: begin
          state     <= RENABLE;
          penable   <= 1'b1;
          hreadyout <= 1'b1;
        end
        WWAIT: begin
          state     <= WRITE;
          pselx     <= 4'b0001 << addr_r_off[REGION_BITS+1:REGION_BITS];
          paddr     <= addr_r;
          pwrite    <= write_r;
          pwdata    <= hwdata;
          penable   <= 1'b0;
          hreadyout <= 1'b0;
        end
        WRITE: begin
          state     <= WENABLE;
          penable   <= 1'b1;
          hreadyout <= 1'b1;
        end
`ifdef BRIDGE_ERROR_RESP_EN
        ERR1: begin
          state     <= ERR2;
          hreadyout <= 1'b1;
        end
`endif
        default: begin
          state     <= IDLE;
          pselx     <= '0;
          penable   <= 1'b0;
          hreadyout <= 1'b1;
          hresp     <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modport_bridge.sv
// tb/tb_modport_bridge.sv - randomized self-checking bench for modport_bridge.
module tb_modport_bridge;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] REGION = 32'd67108864;

  logic        clk = 1'b0;
  logic        hresetn;
  logic [1:0]  htrans;
  logic        hwrite;
  logic        hreadyin;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  hburst;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        pwrite;
  logic [3:0]  pselx;
  logic        penable;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  modport_bridge dut (
    .clk(clk), .hresetn(hresetn), .htrans(htrans), .hwrite(hwrite), .hreadyin(hreadyin),
    .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hburst(hburst), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .pwrite(pwrite), .pselx(pselx), .penable(penable),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: which 64 MB region of the four-slave window the address lands in.
  function automatic logic [3:0] model_sel(input logic [31:0] a);
    if (a < BASE || a > BASE + 4 * REGION - 1) return 4'b0000;
    return 4'b0001 << ((a - BASE) / REGION);
  endfunction

  // Presents one AHB address phase and follows the bridge through every cycle it should take.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [1:0] trans,
                         input logic rdy, input logic [31:0] wdata, input logic [31:0] rdata);
    logic [3:0] sel;
    logic       ok;
    sel = model_sel(addr);
    ok  = rdy && (trans >= 2) && (sel != 0);
    haddr = addr; hwrite = wr; htrans = trans; hreadyin = rdy;
    hwdata = $urandom; prdata = rdata;
    hsize = 3'($urandom_range(0, 7)); hburst = 3'($urandom_range(0, 7));
    step();
    if (!ok) begin
      htrans = 2'b00;
`ifdef BRIDGE_ERROR_RESP_EN
      if (rdy && trans >= 2) begin
        n_checks++;
        if ({pselx, penable, hreadyout, hresp} !== {4'b0, 1'b0, 1'b0, 2'b01}) begin
          n_fail++;
          $display("FAIL err1 addr=%h got sel=%b en=%b rdy=%b resp=%b want sel=0000 en=0 rdy=0 resp=01",
                   addr, pselx, penable, hreadyout, hresp);
        end
        step();
        n_checks++;
        if ({pselx, penable, hreadyout, hresp} !== {4'b0, 1'b0, 1'b1, 2'b01}) begin
          n_fail++;
          $display("FAIL err2 addr=%h got sel=%b en=%b rdy=%b resp=%b want sel=0000 en=0 rdy=1 resp=01",
                   addr, pselx, penable, hreadyout, hresp);
        end
        return;
      end
`endif
      n_checks++;
      if ({pselx, penable, hreadyout, hresp} !== {4'b0, 1'b0, 1'b1, 2'b00}) begin
        n_fail++;
        $display("FAIL ignored addr=%h trans=%0d rdy=%b got sel=%b en=%b rdy=%b resp=%b want sel=0000 en=0 rdy=1 resp=00",
                 addr, trans, rdy, pselx, penable, hreadyout, hresp);
      end
    end else if (!wr) begin
      n_checks++;
      if ({pselx, penable, pwrite, hreadyout, hresp, paddr} !== {sel, 1'b0, 1'b0, 1'b0, 2'b00, addr}) begin
        n_fail++;
        $display("FAIL read_setup addr=%h got sel=%b en=%b wr=%b rdy=%b paddr=%h want sel=%b en=0 wr=0 rdy=0 paddr=%h",
                 addr, pselx, penable, pwrite, hreadyout, paddr, sel, addr);
      end
      step();
      n_checks++;
      if ({pselx, penable, pwrite, hreadyout, hresp, hrdata} !== {sel, 1'b1, 1'b0, 1'b1, 2'b00, rdata}) begin
        n_fail++;
        $display("FAIL read_enable addr=%h got sel=%b en=%b rdy=%b hrdata=%h want sel=%b en=1 rdy=1 hrdata=%h",
                 addr, pselx, penable, hreadyout, hrdata, sel, rdata);
      end
    end else begin
      n_checks++;
      if ({pselx, penable, hreadyout, hresp} !== {4'b0, 1'b0, 1'b0, 2'b00}) begin
        n_fail++;
        $display("FAIL write_wait addr=%h got sel=%b en=%b rdy=%b want sel=0000 en=0 rdy=0",
                 addr, pselx, penable, hreadyout);
      end
      htrans = 2'b00;
      hwdata = wdata;
      step();
      hwdata = $urandom;
      n_checks++;
      if ({pselx, penable, pwrite, hreadyout, paddr, pwdata} !== {sel, 1'b0, 1'b1, 1'b0, addr, wdata}) begin
        n_fail++;
        $display("FAIL write_setup addr=%h got sel=%b en=%b wr=%b rdy=%b paddr=%h pwdata=%h want sel=%b en=0 wr=1 rdy=0 paddr=%h pwdata=%h",
                 addr, pselx, penable, pwrite, hreadyout, paddr, pwdata, sel, addr, wdata);
      end
      step();
      n_checks++;
      if ({pselx, penable, pwrite, hreadyout, hresp, pwdata} !== {sel, 1'b1, 1'b1, 1'b1, 2'b00, wdata}) begin
        n_fail++;
        $display("FAIL write_enable addr=%h got sel=%b en=%b wr=%b rdy=%b pwdata=%h want sel=%b en=1 wr=1 rdy=1 pwdata=%h",
                 addr, pselx, penable, pwrite, hreadyout, pwdata, sel, wdata);
      end
    end
  endtask

  task automatic idle_check(input string tag);
    htrans = 2'b00;
    step();
    n_checks++;
    if ({pselx, penable, hreadyout, hresp} !== {4'b0, 1'b0, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL %s got sel=%b en=%b rdy=%b resp=%b want sel=0000 en=0 rdy=1 resp=00",
               tag, pselx, penable, hreadyout, hresp);
    end
  endtask

  task automatic test_reset();
    hresetn = 1'b0; htrans = 2'b00; hwrite = 1'b0; hreadyin = 1'b1; hsize = 3'd2;
    haddr = '0; hwdata = '0; hburst = '0; prdata = '0;
    step();
    n_checks++;
    if ({pselx, penable, pwrite, paddr, pwdata, hreadyout, hresp} !== {4'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state got sel=%b en=%b wr=%b paddr=%h pwdata=%h rdy=%b resp=%b want all zero rdy=1",
               pselx, penable, pwrite, paddr, pwdata, hreadyout, hresp);
    end
    hresetn = 1'b1;
    idle_check("post_reset_idle");
  endtask

  task automatic test_reset_mid_write();
    haddr = 32'h8400_0020; hwrite = 1'b1; htrans = 2'b10; hreadyin = 1'b1;
    step();
    htrans = 2'b00; hwdata = 32'hCAFE_F00D;
    step();
    n_checks++;
    if ({pselx, penable, pwrite} !== {4'b0010, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_write_setup got sel=%b en=%b wr=%b want sel=0010 en=0 wr=1", pselx, penable, pwrite);
    end
    #2 hresetn = 1'b0;
    #1;
    n_checks++;
    if ({pselx, penable, pwrite, hreadyout, hresp} !== {4'b0, 1'b0, 1'b0, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL async_reset got sel=%b en=%b wr=%b rdy=%b resp=%b want sel=0000 en=0 wr=0 rdy=1 resp=00",
               pselx, penable, pwrite, hreadyout, hresp);
    end
    step();
    hresetn = 1'b1;
    n_checks++;
    if ({pselx, penable} !== {4'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL no_enable_after_reset got sel=%b en=%b want sel=0000 en=0", pselx, penable);
    end
    idle_check("reset_recovery_idle");
  endtask

  task automatic test_single_write();
    do_xfer(32'h8000_0010, 1'b1, 2'd2, 1'b1, 32'hDEAD_BEEF, 32'h0);
    idle_check("write_return_idle");
  endtask

  task automatic test_single_read();
    do_xfer(32'h8800_0004, 1'b0, 2'd2, 1'b1, 32'h0, 32'h1234_5678);
    idle_check("read_return_idle");
  endtask

  task automatic test_back_to_back();
    do_xfer(32'h8400_0000, 1'b0, 2'd2, 1'b1, 32'h0, 32'hA5A5_0001);
    do_xfer(32'h8C00_0000, 1'b0, 2'd3, 1'b1, 32'h0, 32'h5A5A_0002);
    do_xfer(32'h8FFF_FFFC, 1'b1, 2'd3, 1'b1, 32'h1111_2222, 32'h0);
    do_xfer(32'h8000_0000, 1'b1, 2'd2, 1'b1, 32'h3333_4444, 32'h0);
    idle_check("b2b_return_idle");
  endtask

  task automatic test_ignored();
    do_xfer(32'h8000_0000, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0);
    do_xfer(32'h9000_0000, 1'b0, 2'd2, 1'b1, 32'h0, 32'h0);
    do_xfer(32'h7FFF_FFFC, 1'b1, 2'd3, 1'b1, 32'h0, 32'h0);
    do_xfer(32'h8400_0000, 1'b1, 2'd0, 1'b1, 32'h0, 32'h0);
    idle_check("ignored_idle");
  endtask

  task automatic test_hreadyin();
    do_xfer(32'h8000_0000, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    do_xfer(32'h8000_0000, 1'b0, 2'd2, 1'b1, 32'h0, 32'h0BAD_F00D);
    idle_check("hreadyin_idle");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) a = BASE + ($urandom_range(0, 32'h0FFF_FFFF) & 32'hFFFF_FFFC);
      else a = $urandom;
      do_xfer(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) != 0), $urandom, $urandom);
    end
    idle_check("random_idle");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_ignored();
    test_hreadyin();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
